// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Data-memory slot of the 5-stage RV32E pipeline (MEMPREP/MEMEX).
// Executes LB/LH/LW/LBU/LHU and SB/SH/SW over a single-outstanding
// req/gnt/rvalid data bus and returns the extended load word toward WB.
//
// Handshakes:
//   Core side : a request is accepted in the cycle where req_valid=1 and
//               req_ready=1 (req_ready is high only in IDLE). Completion is a
//               one-cycle rsp_valid pulse; rsp_data/fault/misaligned are only
//               meaningful in that cycle. stall is high while a bus access is
//               in flight, so the core holds MEMPREP.
//   Bus side  : bus_req stays high with stable addr/we/wdata/wstrb until the
//               cycle with bus_gnt=1. A write completes on gnt; a read then
//               waits for bus_rvalid=1 with bus_rdata.
//
// Ports:
//   clk, cpu_rst (async, active-low)
//   req_valid/req_we/req_funct3/req_addr/req_wdata : request from MEMPREP
//   req_ready, stall                                 : flow control to core
//   rsp_valid, rsp_data, fault, misaligned           : completion pulse
//   bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb      : data bus request
//   bus_gnt/bus_rvalid/bus_rdata                     : data bus response
//   dbg_state                                        : current FSM state
//
// Parameters:
//   ADDR_W         : width of the word address bus_addr (req_addr[ADDR_W+1:2])
//   TIMEOUT_CYCLES : cycles allowed in ISSUE+WAIT before a fault; 0 disables
//
// Build option:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned halfword/word accesses
//   are not issued; they complete next cycle with misaligned=1. When not
//   defined, the low address bits are masked to the access size and the
//   misaligned output is always 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module load_store_unit #(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              cpu_rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              fault,
  output logic              misaligned,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Access size comes from funct3[1:0] for both loads and stores:
  // 00 byte, 01 halfword, 1x word (covers the reserved encodings).
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Captured request
  logic               we_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [1:0]         off_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;

  // Registered completion pulse
  logic               rsp_valid_q, rsp_valid_d;
  logic               fault_q, fault_d;
  logic               mis_q, mis_d;
  logic [31:0]        rsp_data_q, rsp_data_d;

  logic               accept;
  logic               trap;
  logic               mis_c;
  logic               timeout_hit;
  logic [1:0]         off_eff;
  logic [3:0]         wstrb_c;
  logic [31:0]        wdata_c;
  logic [31:0]        shifted;
  logic [31:0]        load_ext;

  // Address bits above the bus word address are not used by this bus.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign accept = req_valid && (state_q == S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_c = ((req_funct3[1:0] == SZ_H) && req_addr[0]) ||
                 (req_funct3[1] && (req_addr[1:0] != 2'b00));
`else
  assign mis_c = 1'b0;
`endif

  assign trap        = accept && mis_c;
  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  // Lane offset after masking to the access size; an aligned access is
  // unaffected, a misaligned one (only reachable without the trap) is
  // forced down to its natural boundary.
  always_comb begin
    case (req_funct3[1:0])
      SZ_B:    off_eff = req_addr[1:0];
      SZ_H:    off_eff = {req_addr[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
  end

  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        SZ_B: begin
          wstrb_c = 4'b0001 << off_eff;
          wdata_c = {4{req_wdata[7:0]}};
        end
        SZ_H: begin
          wstrb_c = 4'b0011 << off_eff;
          wdata_c = {2{req_wdata[15:0]}};
        end
        default: begin
          wstrb_c = 4'b1111;
          wdata_c = req_wdata;
        end
      endcase
    end
  end

  // Load alignment and extension
  assign shifted = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      SZ_B:    load_ext = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      SZ_H:    load_ext = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. A bus event in the same cycle as the timeout wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !trap) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus_gnt)          state_d = we_q ? S_IDLE : S_WAIT;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (bus_rvalid || timeout_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Completion flags are computed here and registered so that
  // the pulse appears the cycle after the deciding bus event.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    stall       = (state_q != S_IDLE);
    bus_req     = (state_q == S_ISSUE);
    bus_we      = (state_q == S_ISSUE) && we_q;
    rsp_valid_d = 1'b0;
    fault_d     = 1'b0;
    mis_d       = 1'b0;
    rsp_data_d  = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (trap) begin
          rsp_valid_d = 1'b1;
          mis_d       = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus_gnt) begin
          rsp_valid_d = we_q;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          fault_d     = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = load_ext;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          fault_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Counter holds 0 in IDLE, so it starts from 0 on every entry to ISSUE.
  assign cnt_d = (state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'b0000;
      rsp_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      mis_q       <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else begin
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      fault_q     <= fault_d;
      mis_q       <= mis_d;
      rsp_data_q  <= rsp_data_d;
      if (accept && !trap) begin
        we_q    <= req_we;
        size_q  <= req_funct3[1:0];
        uns_q   <= req_funct3[2];
        off_q   <= off_eff;
        addr_q  <= req_addr[ADDR_W+1:2];
        wdata_q <= wdata_c;
        wstrb_q <= wstrb_c;
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign fault      = fault_q;
  assign misaligned = mis_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_wstrb  = wstrb_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. The main instance uses the default
// timeout; a second instance uses TIMEOUT_CYCLES=4 for the fault cases.
// Driver tasks push the expected completion {cycle, fault, misaligned, data}
// into a queue; monitors pop and compare whenever rsp_valid is seen.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_load_store_unit;

  localparam int ADDR_W = 12;
  localparam int W      = 66;  // {cycle[31:0], fault, misaligned, data[31:0]}

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] cyc = 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Main instance signals
  logic              req_valid, req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic              req_ready, stall, rsp_valid, fault, misaligned;
  logic [31:0]       rsp_data;
  logic              bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata, bus_rdata;
  logic [3:0]        bus_wstrb;
  logic [1:0]        dbg_state;

  // Timeout instance signals
  logic              req_valid_t, req_we_t;
  logic [2:0]        req_funct3_t;
  logic [31:0]       req_addr_t, req_wdata_t;
  logic              req_ready_t, stall_t, rsp_valid_t, fault_t, misaligned_t;
  logic [31:0]       rsp_data_t;
  logic              bus_req_t, bus_we_t, bus_gnt_t, bus_rvalid_t;
  logic [ADDR_W-1:0] bus_addr_t;
  logic [31:0]       bus_wdata_t, bus_rdata_t;
  logic [3:0]        bus_wstrb_t;
  logic [1:0]        dbg_state_t;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .cpu_rst(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .fault(fault), .misaligned(misaligned),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .dbg_state(dbg_state)
  );

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .cpu_rst(rst_n),
    .req_valid(req_valid_t), .req_we(req_we_t), .req_funct3(req_funct3_t),
    .req_addr(req_addr_t), .req_wdata(req_wdata_t),
    .req_ready(req_ready_t), .stall(stall_t),
    .rsp_valid(rsp_valid_t), .rsp_data(rsp_data_t), .fault(fault_t), .misaligned(misaligned_t),
    .bus_req(bus_req_t), .bus_we(bus_we_t), .bus_addr(bus_addr_t),
    .bus_wdata(bus_wdata_t), .bus_wstrb(bus_wstrb_t),
    .bus_gnt(bus_gnt_t), .bus_rvalid(bus_rvalid_t), .bus_rdata(bus_rdata_t),
    .dbg_state(dbg_state_t)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_t_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_rsp(input string tag, input logic [W-1:0] e, input logic [31:0] data,
                         input logic flt, input logic mis);
    chk({tag, "_data"},  data,           e[31:0]);
    chk({tag, "_fault"}, {31'b0, flt},   {31'b0, e[33]});
    chk({tag, "_mis"},   {31'b0, mis},   {31'b0, e[32]});
    chk({tag, "_cycle"}, cyc,            e[65:34]);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
        else cmp_rsp("rsp", exp_q.pop_front(), rsp_data, fault, misaligned);
      end else if (fault || misaligned) begin
        chk("flag_without_rsp", {30'b0, fault, misaligned}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid_t) begin
        if (exp_t_q.size() == 0) chk("unexpected_rsp_t", {31'b0, rsp_valid_t}, 32'd0);
        else cmp_rsp("rsp_t", exp_t_q.pop_front(), rsp_data_t, fault_t, misaligned_t);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (main instance)
  // gd: ISSUE cycles before gnt; rd: WAIT cycles before rvalid
  // ---------------------------------------------------------------------------
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                         input int gd, input int rd, input logic [31:0] exp_data,
                         input logic [ADDR_W-1:0] exp_baddr, input logic exp_trap);
    logic [31:0] ecyc;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = addr;
    req_wdata = $urandom_range(0, 32'hFFFF);
    if (exp_trap) begin
      ecyc = cyc + 32'd1;
      exp_q.push_back({ecyc, 1'b0, 1'b1, 32'h0});
      @(negedge clk);
      req_valid = 1'b0;
      chk("trap_no_bus_req", {31'b0, bus_req}, 32'd0);
      chk("trap_no_stall",   {31'b0, stall},   32'd0);
      @(negedge clk);
      chk("trap_no_bus_req2", {31'b0, bus_req}, 32'd0);
      return;
    end
    ecyc = cyc + 32'd3 + 32'(gd) + 32'(rd);
    exp_q.push_back({ecyc, 1'b0, 1'b0, exp_data});
    @(negedge clk);
    req_valid = 1'b0;
    chk("ld_bus_addr", {{(32-ADDR_W){1'b0}}, bus_addr}, {{(32-ADDR_W){1'b0}}, exp_baddr});
    chk("ld_bus_we",   {31'b0, bus_we}, 32'd0);
    for (int i = 0; i < gd; i++) begin
      chk("ld_req_held", {31'b0, bus_req}, 32'd1);
      chk("ld_stall_issue", {31'b0, stall}, 32'd1);
      @(negedge clk);
    end
    chk("ld_req_at_gnt", {31'b0, bus_req}, 32'd1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("ld_req_drop", {31'b0, bus_req}, 32'd0);
    for (int i = 0; i < rd; i++) begin
      chk("ld_stall_wait", {31'b0, stall}, 32'd1);
      @(negedge clk);
    end
    chk("ld_stall_rv", {31'b0, stall}, 32'd1);
    bus_rvalid = 1'b1; bus_rdata = rdata;
    @(negedge clk);
    bus_rvalid = 1'b0; bus_rdata = $urandom;
    chk("ld_idle_after", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                          input int gd, input logic [ADDR_W-1:0] exp_baddr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                          input logic exp_trap);
    logic [31:0] ecyc;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    if (exp_trap) begin
      ecyc = cyc + 32'd1;
      exp_q.push_back({ecyc, 1'b0, 1'b1, 32'h0});
      @(negedge clk);
      req_valid = 1'b0;
      chk("st_trap_no_req", {31'b0, bus_req}, 32'd0);
      @(negedge clk);
      chk("st_trap_no_req2", {31'b0, bus_req}, 32'd0);
      return;
    end
    ecyc = cyc + 32'd2 + 32'(gd);
    exp_q.push_back({ecyc, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i <= gd; i++) begin
      chk("st_bus_req",   {31'b0, bus_req}, 32'd1);
      chk("st_bus_we",    {31'b0, bus_we},  32'd1);
      chk("st_bus_addr",  {{(32-ADDR_W){1'b0}}, bus_addr}, {{(32-ADDR_W){1'b0}}, exp_baddr});
      chk("st_bus_wstrb", {28'b0, bus_wstrb}, {28'b0, exp_strb});
      chk("st_bus_wdata", bus_wdata, exp_wdata);
      if (i == gd) bus_gnt = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("st_idle_after", {31'b0, req_ready}, 32'd1);
    chk("st_req_drop",   {31'b0, bus_req},   32'd0);
  endtask

  // Reset asserted mid-transaction (ISSUE or WAIT); the response must vanish.
  task automatic do_reset_mid(input logic in_wait);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_pre_req", {31'b0, bus_req}, 32'd1);
    if (in_wait) begin
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      chk("rst_pre_wait_stall", {31'b0, stall}, 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_bus_req",   {31'b0, bus_req},   32'd0);
    chk("rst_async_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_async_stall",     {31'b0, stall},     32'd0);
    chk("rst_async_state",     {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("rst_stray_rvalid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rst_stray_rvalid2", {31'b0, rsp_valid}, 32'd0);
  endtask

  // Timeout instance: load never granted (grant=0) or granted but no rvalid.
  task automatic do_timeout(input logic grant);
    logic [31:0] ecyc;
    @(negedge clk);
    req_valid_t = 1'b1; req_we_t = 1'b0; req_funct3_t = 3'b010; req_addr_t = 32'h10;
    ecyc = cyc + 32'd5;  // ISSUE entered at +1, fault 4 cycles later
    exp_t_q.push_back({ecyc, 1'b1, 1'b0, 32'h0});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_valid_t = 1'b0;
      bus_gnt_t = grant && (k == 1);
      chk("to_stall", {31'b0, stall_t}, 32'd1);
      chk("to_bus_req", {31'b0, bus_req_t}, {31'b0, (!grant || k == 1)});
    end
    @(negedge clk);
    bus_gnt_t = 1'b0;
    chk("to_back_idle",  {31'b0, req_ready_t}, 32'd1);
    chk("to_req_low",    {31'b0, bus_req_t},   32'd0);
    bus_rvalid_t = 1'b1; bus_rdata_t = 32'h1234_5678;
    @(negedge clk);
    bus_rvalid_t = 1'b0;
    chk("to_stray_rvalid", {31'b0, rsp_valid_t}, 32'd0);
    @(negedge clk);
    chk("to_stray_rvalid2", {31'b0, rsp_valid_t}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] ecyc;
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    req_valid_t = 0; req_we_t = 0; req_funct3_t = 0; req_addr_t = 0; req_wdata_t = 0;
    bus_gnt_t = 0; bus_rvalid_t = 0; bus_rdata_t = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_stall",     {31'b0, stall},     32'd0);
    chk("reset_bus_req",   {31'b0, bus_req},   32'd0);
    chk("reset_bus_we",    {31'b0, bus_we},    32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_data",  rsp_data,           32'd0);
    chk("reset_flags",     {30'b0, fault, misaligned}, 32'd0);
    chk("reset_bus_addr",  {{(32-ADDR_W){1'b0}}, bus_addr}, 32'd0);
    chk("reset_bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
    chk("reset_bus_wdata", bus_wdata,          32'd0);
    chk("reset_state",     {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //       f3      addr          rdata         gd rd exp           baddr    trap
    do_load (3'b000, 32'h0000_0103, 32'h80AA_5511, 0, 0, 32'hFFFF_FF80, 12'h040, 1'b0);
    do_load (3'b100, 32'h0000_0103, 32'h80AA_5511, 0, 0, 32'h0000_0080, 12'h040, 1'b0);
    do_store(3'b001, 32'h0000_0202, 32'h0000_BEEF, 0, 12'h080, 4'b1100, 32'hBEEF_BEEF, 1'b0);
    do_load (3'b010, 32'h0000_0010, 32'h1234_5678, 3, 2, 32'h1234_5678, 12'h004, 1'b0);
    do_load (3'b001, 32'h0000_0002, 32'h8001_7FFF, 0, 0, 32'hFFFF_8001, 12'h000, 1'b0);
    do_load (3'b101, 32'h0000_0002, 32'h8001_7FFF, 0, 0, 32'h0000_8001, 12'h000, 1'b0);
    do_store(3'b000, 32'h0000_0001, 32'h1234_56A5, 0, 12'h000, 4'b0010, 32'hA5A5_A5A5, 1'b0);
    do_store(3'b010, 32'h0000_03FC, 32'hDEAD_BEEF, 1, 12'h0FF, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    do_load (3'b000, 32'h0000_0000, 32'h0000_007F, 0, 0, 32'h0000_007F, 12'h000, 1'b0);
    do_load (3'b011, 32'h0000_0008, 32'hCAFE_F00D, 0, 1, 32'hCAFE_F00D, 12'h002, 1'b0);
    do_store(3'b111, 32'h0000_000C, 32'h0102_0304, 2, 12'h003, 4'b1111, 32'h0102_0304, 1'b0);
    do_load (3'b010, 32'hFFFF_4004, 32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D, 12'h001, 1'b0);
    do_load (3'b000, 32'h0000_0002, 32'h00C3_0000, 1, 3, 32'hFFFF_FFC3, 12'h000, 1'b0);

    // Misaligned accesses: trapped, or masked to the natural boundary
    do_load (3'b010, 32'h0000_0006, 32'h1122_3344, 0, 0, 32'h1122_3344, 12'h001, TRAP_EN);
    do_load (3'b001, 32'h0000_0001, 32'hA5A5_8421, 0, 0, 32'hFFFF_8421, 12'h000, TRAP_EN);
    do_store(3'b001, 32'h0000_0003, 32'h0000_CAFE, 0, 12'h000, 4'b1100, 32'hCAFE_CAFE, TRAP_EN);
    do_load (3'b110, 32'h0000_000E, 32'h5566_7788, 0, 0, 32'h5566_7788, 12'h003, TRAP_EN);

    // Reset in ISSUE and in WAIT, then a normal load to show recovery
    do_reset_mid(1'b0);
    do_reset_mid(1'b1);
    do_load (3'b010, 32'h0000_0020, 32'hA0B0_C0D0, 0, 0, 32'hA0B0_C0D0, 12'h008, 1'b0);

    // Timeout instance
    do_timeout(1'b0);
    do_timeout(1'b1);
    @(negedge clk);
    req_valid_t = 1'b1; req_we_t = 1'b0; req_funct3_t = 3'b001; req_addr_t = 32'h0;
    ecyc = cyc + 32'd4;
    exp_t_q.push_back({ecyc, 1'b0, 1'b0, 32'hFFFF_8000});
    @(negedge clk);
    req_valid_t = 1'b0; bus_gnt_t = 1'b1;
    @(negedge clk);
    bus_gnt_t = 1'b0;
    @(negedge clk);
    bus_rvalid_t = 1'b1; bus_rdata_t = 32'h0000_8000;
    @(negedge clk);
    bus_rvalid_t = 1'b0;

    repeat (4) @(negedge clk);
    chk("exp_q_drained",   32'(exp_q.size()),   32'd0);
    chk("exp_t_q_drained", 32'(exp_t_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Services the MEMPREP/MEMEX data-memory slot of the 5-stage RV32E pipeline: loads LB/LH/LW/LBU/LHU and stores SB/SH/SW.
- Takes the effective address (alu_result_MEMPREP), store data (rs2) and funct3 from MEMPREP.
- Drives a single-outstanding req/gnt/rvalid data bus and returns the extended load word toward WB.
- Holds the pipeline through `stall` while a bus transaction is in flight.

Parameters:
- ADDR_W, 12, width of bus_addr; word address taken from req_addr[ADDR_W+1:2].
- TIMEOUT_CYCLES, 255, maximum cycles spent in ISSUE+WAIT before a fault; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- cpu_rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  MEMPREP holds a valid memory op (already qualified by ~invalid)
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32 load/store funct3
- req_addr  in  32  effective byte address
- req_wdata  in  32  store data (rs2)
- req_ready  out  1  unit can accept a request
- stall  out  1  hold IF..MEMPREP
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  extended load data; 0 for stores and faults
- fault  out  1  one-cycle timeout pulse, coincident with rsp_valid
- misaligned  out  1  one-cycle misalignment pulse, coincident with rsp_valid
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  word address
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte enables
- bus_gnt  in  1  request accepted (writes complete on gnt)
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read word

Behaviour:
Reset:
- Async, active-low.
- state=IDLE; all outputs 0 except req_ready=1.
- Counter and captured request cleared.
- Reset mid-transaction drops bus_req immediately.
- A bus_rvalid arriving after reset is ignored.

FSM:
- IDLE: req_ready=1, stall=0. Accept when req_valid & req_ready.
  - Capture we, funct3, addr[1:0], word address, wdata, wstrb.
  - Go to ISSUE next cycle.
- ISSUE: bus_req=1, bus outputs held stable.
  - On bus_gnt: a store goes to IDLE with rsp_valid=1 the following cycle; a load goes to WAIT.
- WAIT: on bus_rvalid, latch the extended data into rsp_data, pulse rsp_valid, go to IDLE.
- stall = (state != IDLE).

Timing:
- Load latency with gnt and rvalid at first opportunity: accept at T, bus_req at T+1, rvalid at T+2, rsp_valid at T+3.
- Store: accept at T, gnt at T+1, rsp_valid at T+2.

Timeout:
- Counter is cleared on entry to ISSUE and increments every cycle in ISSUE or WAIT.
- On reaching TIMEOUT_CYCLES: go to IDLE and pulse fault+rsp_valid with rsp_data=0.
- A later stray rvalid is ignored.

Width and lane rules (off=addr[1:0]):
- Store byte lanes:
  - SB: bus_wstrb = 0001<<off, bus_wdata = {4{wdata[7:0]}}.
  - SH: bus_wstrb = 0011<<off, bus_wdata = {2{wdata[15:0]}}.
  - SW: bus_wstrb = 1111.
- Loads: shift bus_rdata right by 8*off, then:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- Reserved funct3: loads with 011/110/111 are treated as LW; stores use funct3[1:0], with 11 treated as SW.
- Stores never modify rsp_data beyond driving 0.

Boundaries:
- A req_valid held during stall is not re-accepted; the core holds MEMPREP.
- rsp_valid and a new accept never overlap, because accept only happens in IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with off[0]=1, or LW/SW with off!=0, issue no bus access. Next cycle the unit pulses misaligned=1 and rsp_valid=1 with rsp_data=0; state stays IDLE and no write occurs.
- Undefined: the misalignment check is absent. Halfword ops clear off[0] and word ops clear off[1:0] before lane selection; the misaligned port is tied 0.

Test Plan:
- LB at addr 0x103, rdata 0x80AA5511, gnt+rvalid immediate -> rsp_data=0xFFFFFF80 at T+3; LBU same -> 0x00000080.
- SH at addr 0x202, wdata 0x0000BEEF -> bus_addr=0x080, bus_wstrb=1100, bus_wdata=0xBEEFBEEF, rsp_valid at T+2, rsp_data=0.
- LW, gnt delayed 3 cycles, rvalid 2 cycles later, rdata 0x12345678 -> stall high throughout ISSUE/WAIT, rsp_data=0x12345678, bus_req held until gnt.
- TIMEOUT_CYCLES=4, load never granted -> fault=rsp_valid=1 exactly 4 cycles after entering ISSUE, rsp_data=0, back to IDLE; a later rvalid has no effect.
- cpu_rst asserted in WAIT -> bus_req=0 and req_ready=1 asynchronously; rvalid after release -> no rsp_valid.
- LW at 0x006: with LSU_MISALIGN_TRAP_EN -> misaligned=rsp_valid=1, bus_req never high; without it -> bus_addr=0x001, normal word load.
